io_bus_arbiter: RTL and testbench

- Two-master, one-target arbiter for the internal I/O register bus (io_req/ack/wrt/address/wdata/rdata/rdata_en protocol).
- Shares the system-register / peripheral I/O space between the cartridge-side bus bridge (master 0) and the internal controller (master 1).
- Sequences one transaction at a time: grant, forward, wait ack, wait read data, return. Round-robin fairness; timeout recovery returns open-bus FFh.

---
 rtl/io_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master, one-target arbiter for the internal I/O register bus.
// Serialises transactions with round-robin fairness and timeout recovery (open-bus FFh).
module io_bus_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned RD_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_io_req,
  output logic        m0_ack,
  input  logic        m0_wrt,
  input  logic [15:0] m0_address,
  input  logic [7:0]  m0_wdata,
  output logic [7:0]  m0_rdata,
  output logic        m0_rdata_en,

  input  logic        m1_io_req,
  output logic        m1_ack,
  input  logic        m1_wrt,
  input  logic [15:0] m1_address,
  input  logic [7:0]  m1_wdata,
  output logic [7:0]  m1_rdata,
  output logic        m1_rdata_en,

  output logic        bus_io_req,
  input  logic        bus_ack,
  output logic        bus_wrt,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_rdata_en
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RD_WAIT,
    ABORT_RD
  } state_t;

  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RD_LAST  = 8'(RD_TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [7:0]  timer;

  logic        pick;
  logic        ack_expired;
  logic        rd_expired;
  logic        req_done;
  logic        ret_fire;
  logic [7:0]  ret_data;

  // On a tie the master that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (m0_io_req && m1_io_req) pick = ~last_grant;
    else if (m1_io_req)         pick = 1'b1;
  end

  assign ack_expired = (timer == ACK_LAST);
  assign rd_expired  = (timer == RD_LAST);

  // A timed-out request is still acknowledged so the master releases its request.
  assign req_done = (state == REQ) && (bus_ack || ack_expired);
  assign m0_ack   = req_done && !grant;
  assign m1_ack   = req_done &&  grant;

  always_comb begin
    ret_fire = 1'b0;
    ret_data = bus_rdata;
    if (state == ABORT_RD) begin
      ret_fire = 1'b1;
      ret_data = 8'hFF;
    end else if (state == RD_WAIT && bus_rdata_en) begin
      ret_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      timer       <= '0;
      bus_io_req  <= 1'b0;
      bus_wrt     <= 1'b0;
      bus_address <= '0;
      bus_wdata   <= '0;
      m0_rdata    <= '0;
      m0_rdata_en <= 1'b0;
      m1_rdata    <= '0;
      m1_rdata_en <= 1'b0;
    end else begin
      m0_rdata_en <= ret_fire && !grant;
      m1_rdata_en <= ret_fire &&  grant;
      if (ret_fire && !grant) m0_rdata <= ret_data;
      if (ret_fire &&  grant) m1_rdata <= ret_data;

      case (state)
        IDLE: begin
          if (m0_io_req || m1_io_req) begin
            grant       <= pick;
            bus_wrt     <= pick ? m1_wrt     : m0_wrt;
            bus_address <= pick ? m1_address : m0_address;
            bus_wdata   <= pick ? m1_wdata   : m0_wdata;
            bus_io_req  <= 1'b1;
            timer       <= '0;
            state       <= REQ;
          end
        end

        REQ: begin
          if (bus_ack) begin
            bus_io_req <= 1'b0;
            last_grant <= grant;
            timer      <= '0;
            state      <= bus_wrt ? IDLE : RD_WAIT;
          end else if (ack_expired) begin
            bus_io_req <= 1'b0;
            last_grant <= grant;
            timer      <= '0;
            state      <= bus_wrt ? IDLE : ABORT_RD;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        RD_WAIT: begin
          if (bus_rdata_en) begin
            timer <= '0;
            state <= IDLE;
          end else if (rd_expired) begin
            timer <= '0;
            state <= ABORT_RD;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        ABORT_RD: begin
          timer <= '0;
          state <= IDLE;
        end

        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: masters push planned responses, a target
// model replays them, and a monitor checks returned read data against the plan.
module tb_io_bus_arbiter;

  localparam int ACK_T = 16;
  localparam int RD_T  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_io_req, m0_ack, m0_wrt, m0_rdata_en;
  logic [15:0] m0_address;
  logic [7:0]  m0_wdata, m0_rdata;
  logic        m1_io_req, m1_ack, m1_wrt, m1_rdata_en;
  logic [15:0] m1_address;
  logic [7:0]  m1_wdata, m1_rdata;
  logic        bus_io_req, bus_ack, bus_wrt, bus_rdata_en;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata, bus_rdata;

  io_bus_arbiter #(.ACK_TIMEOUT(ACK_T), .RD_TIMEOUT(RD_T)) dut (
    .clk(clk), .reset(reset),
    .m0_io_req(m0_io_req), .m0_ack(m0_ack), .m0_wrt(m0_wrt), .m0_address(m0_address),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_rdata_en(m0_rdata_en),
    .m1_io_req(m1_io_req), .m1_ack(m1_ack), .m1_wrt(m1_wrt), .m1_address(m1_address),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_rdata_en(m1_rdata_en),
    .bus_io_req(bus_io_req), .bus_ack(bus_ack), .bus_wrt(bus_wrt), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic        wrt;
    logic [7:0]  wdata;
    int          ack_d;
    int          rd_d;
    logic [7:0]  rdata;
    int          issue_cyc;
    bit          chk_lat;
  } plan_t;

  typedef struct {
    logic [7:0] data;
    bit         timed;
  } exp_t;

  plan_t plan_q0[$];
  plan_t plan_q1[$];
  exp_t  exp_q0[$];
  exp_t  exp_q1[$];
  int    order_log[$];
  int    rden_cyc = 0;
  int    total = 0;
  int    bad = 0;

  logic [63:0] all_out;
  assign all_out = {18'b0, bus_io_req, bus_wrt, bus_address, bus_wdata, m0_ack, m1_ack,
                    m0_rdata_en, m1_rdata_en, m0_rdata, m1_rdata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One master transaction; the target behaviour it expects travels with it.
  task automatic issue(input int m, input logic [15:0] addr, input logic wrt,
                       input logic [7:0] wdata, input int ack_d, input int rd_d,
                       input logic [7:0] rdata, input int gap, input bit chk_lat);
    plan_t p;
    exp_t  e;
    bit    got;
    repeat (gap) @(posedge clk);
    #1;
    p.addr = addr; p.wrt = wrt; p.wdata = wdata; p.ack_d = ack_d; p.rd_d = rd_d;
    p.rdata = rdata; p.issue_cyc = cyc; p.chk_lat = chk_lat;
    if (!wrt) begin
      e.timed = (ack_d < ACK_T) && (rd_d <= RD_T);
      e.data  = e.timed ? rdata : 8'hFF;
      if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    if (m == 0) begin
      plan_q0.push_back(p);
      m0_wrt = wrt; m0_address = addr; m0_wdata = wdata; m0_io_req = 1'b1;
    end else begin
      plan_q1.push_back(p);
      m1_wrt = wrt; m1_address = addr; m1_wdata = wdata; m1_io_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack : m1_ack;
    end
    check($sformatf("ack_m%0d", m), 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if (m == 0) m0_io_req = 1'b0; else m1_io_req = 1'b0;
  endtask

  task automatic rand_txn(input int m);
    logic [15:0] a;
    int r, ad, rd;
    a = (m == 0) ? {1'b0, 15'($urandom)} : {1'b1, 15'($urandom)};
    r = $urandom_range(0, 9);
    ad = (r < 6) ? r % 4 : (r == 6) ? ACK_T - 1 : (r == 7) ? 255 : r - 8;
    r = $urandom_range(0, 9);
    rd = (r < 6) ? 1 + r % 3 : (r == 6) ? RD_T : (r == 7) ? 99 : 1;
    issue(m, a, 1'($urandom), 8'($urandom), ad, rd, 8'($urandom), $urandom_range(1, 4), 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < 300 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(posedge clk);
    check("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  // Target model: replays the plan attached to whichever master's request is on the bus.
  initial begin
    plan_t p;
    int    src;
    int    n;
    bit    h0, h1;
    bus_ack = 1'b0; bus_rdata_en = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus_io_req) begin
        h0 = plan_q0.size() > 0 && plan_q0[0].addr == bus_address;
        h1 = plan_q1.size() > 0 && plan_q1[0].addr == bus_address;
        total++;
        if (h0) begin p = plan_q0.pop_front(); src = 0; end
        else if (h1) begin p = plan_q1.pop_front(); src = 1; end
        else begin
          bad++; src = -1;
          $display("FAIL bus_address: got %0h want a pending master address", bus_address);
          p.wrt = bus_wrt; p.ack_d = 0; p.rd_d = 1; p.rdata = 8'h00; p.chk_lat = 1'b0;
        end
        if (src >= 0) begin
          order_log.push_back(src);
          check("bus_wrt", 64'(bus_wrt), 64'(p.wrt));
          if (p.wrt) check("bus_wdata", 64'(bus_wdata), 64'(p.wdata));
          if (p.chk_lat) check("req_latency", 64'(cyc), 64'(p.issue_cyc + 1));
        end
        if (p.ack_d < ACK_T) begin
          repeat (p.ack_d) begin @(posedge clk); #1; end
          bus_ack = 1'b1;
          @(posedge clk);
          #1;
          bus_ack = 1'b0;
          check("req_drop", 64'(bus_io_req), 64'd0);
          if (!p.wrt && p.rd_d <= RD_T) begin
            repeat (p.rd_d - 1) begin @(posedge clk); #1; end
            bus_rdata = p.rdata; bus_rdata_en = 1'b1; rden_cyc = cyc;
            @(posedge clk);
            #1;
            bus_rdata_en = 1'b0; bus_rdata = 8'($urandom);
          end
        end else begin
          n = 1;
          while (bus_io_req && n < 64) begin
            @(posedge clk);
            #1;
            if (bus_io_req) n++;
          end
          check("req_timeout_len", 64'(n), 64'(ACK_T));
        end
      end
    end
  end

  // Monitor: pops expected read results as the arbiter returns them.
  task automatic rd_check(input int m, input logic [7:0] data);
    exp_t e;
    if ((m == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      total++; bad++;
      $display("FAIL rdata_en_m%0d: got unexpected pulse want none", m);
    end else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("rdata_m%0d", m), 64'(data), 64'(e.data));
      if (e.timed) check($sformatf("rdata_latency_m%0d", m), 64'(cyc), 64'(rden_cyc + 1));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m0_rdata_en) rd_check(0, m0_rdata);
        if (m1_rdata_en) rd_check(1, m1_rdata);
        if ((m0_ack && !m0_io_req) || (m1_ack && !m1_io_req) || (m0_ack && m1_ack)) begin
          total++; bad++;
          $display("FAIL stray_ack: got m0=%0b m1=%0b want ack only to the requester", m0_ack, m1_ack);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m0_io_req = 1'b0; m0_wrt = 1'b0; m0_address = '0; m0_wdata = '0;
    m1_io_req = 1'b0; m1_wrt = 1'b0; m1_address = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_out, 64'd0);
    reset = 1'b0;

    issue(0, 16'h00F3, 1'b1, 8'h12, 1, 0, 8'h00, 2, 1'b1);
    drain();
    issue(1, 16'h00F4, 1'b0, 8'h00, 0, 2, 8'h5A, 1, 1'b1);
    drain();
    check("m1_rdata_5a", 64'(m1_rdata), 64'h5A);

    order_log.delete();
    fork
      begin
        issue(0, 16'h00F3, 1'b1, 8'hA1, 0, 0, 8'h00, 1, 1'b0);
        issue(0, 16'h00F3, 1'b1, 8'hA2, 1, 0, 8'h00, 1, 1'b0);
      end
      begin
        issue(1, 16'h00F5, 1'b1, 8'hB1, 2, 0, 8'h00, 1, 1'b0);
        issue(1, 16'h00F5, 1'b1, 8'hB2, 0, 0, 8'h00, 1, 1'b0);
      end
    join
    drain();
    check("rr_count", 64'(order_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < order_log.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(order_log[i]), 64'(i % 2));

    issue(0, 16'h0010, 1'b1, 8'h01, 0, 0, 8'h00, 1, 1'b0);
    drain();
    order_log.delete();
    fork
      issue(0, 16'h0011, 1'b1, 8'h02, 0, 0, 8'h00, 1, 1'b0);
      issue(1, 16'h0012, 1'b1, 8'h03, 0, 0, 8'h00, 1, 1'b0);
    join
    drain();
    check("tie_after_m0", 64'(order_log.size() > 0 ? order_log[0] : -1), 64'd1);

    issue(0, 16'h00F5, 1'b1, 8'h77, 255, 0, 8'h00, 1, 1'b0);
    issue(1, 16'h00F3, 1'b1, 8'h34, 2, 0, 8'h00, 1, 1'b1);
    drain();
    check("m1_rdata_hold", 64'(m1_rdata), 64'h5A);

    issue(0, 16'h00F3, 1'b0, 8'h00, 0, 99, 8'h00, 1, 1'b0);
    drain();
    issue(0, 16'h00F3, 1'b0, 8'h00, 0, 1, 8'h9A, 1, 1'b0);
    issue(1, 16'h00F6, 1'b0, 8'h00, ACK_T - 1, RD_T, 8'hC3, 1, 1'b0);
    issue(1, 16'h00F7, 1'b0, 8'h00, 255, 0, 8'h00, 1, 1'b0);
    drain();

    // Reset lands while m0's read sits in RD_WAIT; nothing may be returned for it.
    issue(0, 16'h00F3, 1'b0, 8'h00, 0, 99, 8'h00, 1, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("reset_mid_read", all_out, 64'd0);
    exp_q0.delete(); exp_q1.delete(); plan_q0.delete(); plan_q1.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    order_log.delete();
    fork
      issue(0, 16'h0020, 1'b1, 8'h05, 0, 0, 8'h00, 1, 1'b0);
      issue(1, 16'h0021, 1'b1, 8'h06, 0, 0, 8'h00, 1, 1'b0);
    join
    drain();
    check("post_reset_tie", 64'(order_log.size() > 0 ? order_log[0] : -1), 64'd0);

    fork
      for (int i = 0; i < 25; i++) rand_txn(0);
      for (int j = 0; j < 25; j++) rand_txn(1);
    join
    drain();
    repeat (40) @(posedge clk);
    check("plans_consumed", 64'(plan_q0.size() + plan_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
